// File: rtl/inst_rom_loader.sv
// inst_rom_loader: instruction ROM with byte-serial program loader; INST_ROM_ALIGN_CHECK_EN adds addr_misalign
module inst_rom_loader #(
  parameter int    ADDR_W    = 10,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [31:0]       rom_addr_i,
  output logic [31:0]       rom_data_o,
`ifdef INST_ROM_ALIGN_CHECK_EN
  output logic              addr_misalign,
`endif
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_overflow,
  output logic [ADDR_W:0]   load_words
);
  localparam int DEPTH = 2**ADDR_W;
  typedef enum logic [1:0] {IDLE = 2'b00, LOAD = 2'b01, DONE = 2'b10} state_t;
  state_t state, state_n;
  logic [31:0] mem [DEPTH];
  logic [31:0] buffer, word;
  logic [1:0]  byte_cnt;
  logic        accept, commit, full, rd_ok, in_range;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    if (load_start) state_n = LOAD;
    else if (state == LOAD && load_valid && load_last) state_n = DONE;
  end
  assign load_ready = state == LOAD;
  assign load_busy  = state == LOAD;
  assign load_done  = state == DONE;
  assign accept = load_busy && load_valid && !load_start;
  assign commit = accept && (byte_cnt == 2'd3 || load_last);
  assign full = load_words[ADDR_W];
  assign word = buffer | ({24'h0, load_byte} << {~byte_cnt, 3'b000});
  always_ff @(posedge clk) begin
    if (rst || load_start) begin
      buffer        <= '0;
      byte_cnt      <= '0;
      load_words    <= '0;
      load_overflow <= 1'b0;
    end else if (accept) begin
      buffer   <= commit ? '0 : word;
      byte_cnt <= commit ? 2'd0 : byte_cnt + 2'd1;
      if (commit && full) load_overflow <= 1'b1;
      if (commit && !full) load_words <= load_words + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (!rst && commit && !full) mem[load_words[ADDR_W-1:0]] <= word;
  assign rd_ok    = rom_ce_i && !load_busy;
  assign in_range = rom_addr_i[31:ADDR_W+2] == '0;
`ifdef INST_ROM_ALIGN_CHECK_EN
  assign addr_misalign = rd_ok && rom_addr_i[1:0] != 2'b00;
  assign rom_data_o = (rd_ok && in_range && !addr_misalign) ? mem[rom_addr_i[ADDR_W+1:2]] : 32'h0;
`else
  logic unused_low_addr;
  assign unused_low_addr = &{1'b0, rom_addr_i[1:0]};
  assign rom_data_o = (rd_ok && in_range) ? mem[rom_addr_i[ADDR_W+1:2]] : 32'h0;
`endif
endmodule
